// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the 4x4 systolic multiplier. It reads A and B into local buffers,
// clears the array accumulators, then streams skewed, zero-filled rows and columns into it.
module systolic_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_W     = $clog2(MAX_DIM**2),
  parameter int DIM_W      = $clog2(MAX_DIM)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [DIM_W-1:0]              dim_n_i,
  input  logic [DIM_W-1:0]              dim_k_i,
  input  logic [DIM_W-1:0]              dim_m_i,
  output logic                          rd_en_o,
  output logic [ADDR_W-1:0]             addr_a_o,
  output logic [ADDR_W-1:0]             addr_b_o,
  input  logic [DATA_WIDTH-1:0]         rd_data_a_i,
  input  logic [DATA_WIDTH-1:0]         rd_data_b_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] left_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] up_o,
  output logic                          valid_o,
  output logic                          acc_clr_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int IDX_W = DIM_W + 2;
  localparam int DW1   = DIM_W + 1;
  localparam int LD_W  = ADDR_W + 1;
  localparam int NENT  = MAX_DIM * MAX_DIM;
  localparam int SKEW  = 2 * (MAX_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic [LD_W-1:0]               ld_q, ld_d;
  logic [IDX_W-1:0]              step_q, step_d;
  logic [DW1-1:0]                n_q, n_d, k_q, k_d, m_q, m_d;
  logic                          rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [MAX_DIM*DATA_WIDTH-1:0] left_q, left_d, up_q, up_d;
  logic                          valid_q, valid_d;
  logic                          acc_clr_q, acc_clr_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [DATA_WIDTH-1:0] buf_a_q [NENT];
  logic [DATA_WIDTH-1:0] buf_b_q [NENT];

  logic                  cap_en;
  logic [ADDR_W-1:0]     cap_idx;
  logic [IDX_W-1:0]      nxt_step;
  logic [IDX_W-1:0]      last_step;
  logic                  emit;
  logic [DATA_WIDTH-1:0] lane_a [MAX_DIM];
  logic [DATA_WIDTH-1:0] lane_b [MAX_DIM];

  // Read data lags the strobe by one cycle, so load count c captures entry c-1.
  assign cap_en    = (state_q == S_LOAD) && (ld_q != '0);
  assign cap_idx   = ADDR_W'(ld_q - LD_W'(1));
  assign nxt_step  = (state_q == S_LOAD) ? '0 : step_q + IDX_W'(1);
  assign last_step = IDX_W'(k_q) + IDX_W'(SKEW - 1);

  always_ff @(posedge clk_i) begin
    if (cap_en) begin
      buf_a_q[cap_idx] <= rd_data_a_i;
      buf_b_q[cap_idx] <= rd_data_b_i;
    end
  end

  // Lane gi carries element (t - gi) along K; out-of-window steps select zero.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
    localparam logic [IDX_W-1:0] GI = IDX_W'(gi);
    logic [IDX_W-1:0]  off;
    logic              in_k;
    logic              hit_a, hit_b;
    logic [ADDR_W-1:0] idx_a, idx_b;

    assign off   = nxt_step - GI;
    assign in_k  = (nxt_step >= GI) && (off < IDX_W'(k_q));
    assign hit_a = in_k && (GI < IDX_W'(n_q));
    assign hit_b = in_k && (GI < IDX_W'(m_q));
    assign idx_a = ADDR_W'(gi * MAX_DIM) + ADDR_W'(off[DIM_W-1:0]);
    assign idx_b = ADDR_W'(off[DIM_W-1:0]) * ADDR_W'(MAX_DIM) + ADDR_W'(gi);
    assign lane_a[gi] = hit_a ? buf_a_q[idx_a] : '0;
    assign lane_b[gi] = hit_b ? buf_b_q[idx_b] : '0;
  end

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    step_d    = step_q;
    n_d       = n_q;
    k_d       = k_q;
    m_d       = m_q;
    rd_en_d   = 1'b0;
    addr_d    = '0;
    acc_clr_d = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    emit      = 1'b0;
    left_d    = '0;
    up_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d     = {1'b0, dim_n_i} + DW1'(1);
          k_d     = {1'b0, dim_k_i} + DW1'(1);
          m_d     = {1'b0, dim_m_i} + DW1'(1);
          ld_d    = '0;
          rd_en_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_q == LD_W'(NENT)) begin
          step_d  = '0;
          valid_d = 1'b1;
          emit    = 1'b1;
          state_d = S_STREAM;
        end else begin
          ld_d = ld_q + LD_W'(1);
          if (ld_q + LD_W'(1) < LD_W'(NENT)) begin
            rd_en_d = 1'b1;
            addr_d  = ADDR_W'(ld_q + LD_W'(1));
          end else begin
            acc_clr_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (step_q == last_step) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          step_d  = step_q + IDX_W'(1);
          valid_d = 1'b1;
          emit    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        left_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_a[i];
        up_d[i*DATA_WIDTH +: DATA_WIDTH]   = lane_b[i];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ld_q      <= '0;
      step_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      m_q       <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      left_q    <= '0;
      up_q      <= '0;
      valid_q   <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      step_q    <= step_d;
      n_q       <= n_d;
      k_q       <= k_d;
      m_q       <= m_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      up_q      <= up_d;
      valid_q   <= valid_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign addr_a_o  = addr_q;
  assign addr_b_o  = addr_q;
  assign left_o    = left_q;
  assign up_o      = up_q;
  assign valid_o   = valid_q;
  assign acc_clr_o = acc_clr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed and randomised bench for systolic_operand_feeder with a cycle-indexed
// reference model of the load/stream/done timeline.
module tb_systolic_operand_feeder;

  localparam int DW = 32;
  localparam int MD = 4;
  localparam int AW = 4;
  localparam int DMW = 2;
  localparam int NE = MD * MD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [DMW-1:0]    dim_n = '0, dim_k = '0, dim_m = '0;
  logic              rd_en;
  logic [AW-1:0]     addr_a, addr_b;
  logic [DW-1:0]     rd_data_a = '0, rd_data_b = '0;
  logic [MD*DW-1:0]  left, up;
  logic              valid, acc_clr, busy, done;

  logic [DW-1:0] mem_a [NE];
  logic [DW-1:0] mem_b [NE];

  int checks = 0;
  int errors = 0;

  systolic_operand_feeder #(
    .DATA_WIDTH(DW), .MAX_DIM(MD), .ADDR_W(AW), .DIM_W(DMW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .dim_n_i(dim_n), .dim_k_i(dim_k), .dim_m_i(dim_m),
    .rd_en_o(rd_en), .addr_a_o(addr_a), .addr_b_o(addr_b),
    .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b),
    .left_o(left), .up_o(up), .valid_o(valid), .acc_clr_o(acc_clr),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand registers.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[addr_a];
      rd_data_b <= mem_b[addr_b];
    end
  end

  task automatic check(input string tag, input logic [MD*DW-1:0] got, input logic [MD*DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, MD*DW'(rd_en), '0);
    check({tag, "_addr"}, MD*DW'(addr_a), '0);
    check({tag, "_left"}, left, '0);
    check({tag, "_up"}, up, '0);
    check({tag, "_valid"}, MD*DW'(valid), '0);
    check({tag, "_clr"}, MD*DW'(acc_clr), '0);
    check({tag, "_busy"}, MD*DW'(busy), '0);
    check({tag, "_done"}, MD*DW'(done), '0);
  endtask

  // Expected skewed drive for stream step t: lane i gets A[i][t-i], lane j gets B[t-j][j].
  task automatic model_step(input int t, input int n, input int k, input int m,
                            output logic [MD*DW-1:0] el, output logic [MD*DW-1:0] eu);
    el = '0;
    eu = '0;
    for (int i = 0; i < MD; i++) begin
      if (i < n && t - i >= 0 && t - i < k) el[i*DW +: DW] = mem_a[i*MD + (t - i)];
      if (i < m && t - i >= 0 && t - i < k) eu[i*DW +: DW] = mem_b[(t - i)*MD + i];
    end
  endtask

  // Start an op and check every cycle c after the start-sampling edge.
  // Loading occupies c=0..16, streaming c=17..16+L, done at c=17+L, idle at c=18+L.
  // abort_c >= 0 stops at that cycle's negedge instead of finishing.
  task automatic run_op(input int n, input int k, input int m, input bit hold, input int abort_c);
    int L;
    int done_c;
    logic [MD*DW-1:0] el, eu;
    L = k + 2*(MD-1);
    done_c = -1;
    dim_n = DMW'(n-1);
    dim_k = DMW'(k-1);
    dim_m = DMW'(m-1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = hold;
    dim_n = DMW'($urandom);
    dim_k = DMW'($urandom);
    dim_m = DMW'($urandom);
    for (int c = 0; c <= 18 + L; c++) begin
      bit e_rd, e_valid;
      @(negedge clk);
      if (c == abort_c) return;
      e_rd = (c < NE);
      e_valid = (c >= NE + 1 && c < NE + 1 + L);
      if (done) done_c = c;
      check("rd_en", MD*DW'(rd_en), MD*DW'(e_rd));
      if (e_rd) begin
        check("addr_a", MD*DW'(addr_a), MD*DW'(c));
        check("addr_b", MD*DW'(addr_b), MD*DW'(c));
      end
      check("acc_clr", MD*DW'(acc_clr), MD*DW'(c == NE));
      check("valid", MD*DW'(valid), MD*DW'(e_valid));
      check("busy", MD*DW'(busy), MD*DW'(c <= NE + 1 + L));
      check("done", MD*DW'(done), MD*DW'(c == NE + 1 + L));
      if (e_valid) model_step(c - (NE + 1), n, k, m, el, eu);
      else begin el = '0; eu = '0; end
      check("left", left, el);
      check("up", up, eu);
    end
    $display("op n=%0d k=%0d m=%0d L=%0d done_edge=%0d (expected %0d)",
             n, k, m, L, done_c + 1, NE + L + 2);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NE; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
  endtask

  initial begin
    fill_random();
    // Test 1: asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Test 2: full 4x4, A[r][c]=4r+c+1, B identity.
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        mem_a[r*MD + c] = DW'(4*r + c + 1);
        mem_b[r*MD + c] = (r == c) ? DW'(1) : DW'(0);
      end
    run_op(4, 4, 4, 1'b0, -1);

    // Test 3: N=2, K=3, M=2 with random data.
    fill_random();
    run_op(2, 3, 2, 1'b0, -1);

    // Test 4: 1x1x1.
    fill_random();
    mem_a[0] = 32'd5;
    mem_b[0] = 32'd7;
    run_op(1, 1, 1, 1'b0, -1);

    // Test 5: start held through an op and into IDLE.
    fill_random();
    run_op(4, 4, 4, 1'b1, -1);
    run_op(3, 2, 4, 1'b0, -1);

    // Test 6: reset at stream step 4, then a clean restart.
    fill_random();
    run_op(4, 4, 4, 1'b0, NE + 1 + 4);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("abort_hold");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", MD*DW'(done), '0);
      check("abort_idle", MD*DW'(busy), '0);
    end
    run_op(4, 4, 4, 1'b0, -1);

    // Randomised dimensions and data.
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_op(int'($urandom_range(1, MD)), int'($urandom_range(1, MD)),
             int'($urandom_range(1, MD)), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no completion expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
